// File: rtl/mul_div_unit_if.sv
// EX-stage request/result bundle for the HI/LO multiply/divide unit.
// master = EX stage / hazard logic, slave = mul_div_unit.
interface mul_div_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush_Mem;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, flush_Mem,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, flush_Mem,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers.
// Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu (md_op 6..9).
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  md
);

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        busy;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        is_acc;
  logic        is_long;
  logic [4:0]  load_cnt;

  always_comb begin
    accept   = md.start && !md.flush_Mem && (state_q == S_IDLE);
    is_mul   = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    is_div   = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_acc   = (md.md_op >= OP_MADD) && (md.md_op <= OP_MSUBU);
`else
    is_acc   = 1'b0;
`endif
    is_long  = is_mul || is_div || is_acc;
    load_cnt = is_div ? DIV_LOAD : MULT_LOAD;
  end

  // Signed ops share one unsigned magnitude datapath; signs are reapplied afterwards.
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_neg     = signed_op && a_q[31];
    b_neg     = signed_op && b_q[31];
    a_mag     = a_neg ? (32'd0 - a_q) : a_q;
    b_mag     = b_neg ? (32'd0 - b_q) : b_q;
    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    prod      = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
    quo_mag   = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    rem_mag   = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    quo       = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem       = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  logic        wr_en;
  logic [63:0] result_d;

  // HI/LO cannot change while busy, so the live {hi,lo} equals the value at op start.
  always_comb begin
    wr_en    = 1'b0;
    result_d = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: begin
        wr_en    = 1'b1;
        result_d = prod;
      end
      OP_DIV, OP_DIVU: begin
        wr_en    = (b_q != 32'd0);
        result_d = {rem, quo};
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        wr_en    = 1'b1;
        result_d = {hi_q, lo_q} + prod;
      end
      OP_MSUB, OP_MSUBU: begin
        wr_en    = 1'b1;
        result_d = {hi_q, lo_q} - prod;
      end
`endif
      default: begin
        wr_en    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (md.md_op == OP_MTHI) hi_q <= md.rs_val;
            if (md.md_op == OP_MTLO) lo_q <= md.rs_val;
            if (is_long) begin
              state_q <= S_BUSY;
              cnt_q   <= load_cnt;
              op_q    <= md.md_op;
              a_q     <= md.rs_val;
              b_q     <= md.rt_val;
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_q <= S_IDLE;
            if (wr_en) {hi_q, lo_q} <= result_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == S_BUSY);
  assign md.busy     = busy;
  assign md.md_stall = md.start | busy;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// longint reference model, and an asynchronous mid-divide reset sequence.
module tb_mul_div_unit;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mul_div_unit_if ifc();

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush_start;
    int          flush_cyc;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fs, input int fc, input int cyc,
                         input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.name = name; v.op = op; v.rs = rs; v.rt = rt;
    v.flush_start = fs; v.flush_cyc = fc; v.cyc = cyc; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, q, m;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = hl;
    case (op)
      4'd0: r = sa * sb;
      4'd1: r = ua * ub;
      4'd2: if (b != 32'd0) begin
        q = sa / sb;
        m = sa % sb;
        r = {m[31:0], q[31:0]};
      end
      4'd3: if (b != 32'd0) r = {a % b, a / b};
`ifdef MDU_MADD_EN
      4'd6: r = hl + sa * sb;
      4'd7: r = hl + ua * ub;
      4'd8: r = hl - sa * sb;
      4'd9: r = hl - ua * ub;
`endif
      default: r = hl;
    endcase
    return r;
  endfunction

  // Issue one op at a negedge, measure busy length, then pop and compare the scoreboard entry.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fs, input int fc, input int cyc,
                        input logic [31:0] eh, input logic [31:0] el);
    exp_t        e;
    int          n;
    logic [31:0] ph, pl;
    ph = cur_hi;
    pl = cur_lo;
    ifc.start = 1'b1; ifc.md_op = op; ifc.rs_val = rs; ifc.rt_val = rt; ifc.flush_Mem = fs;
    #1;
    chk({name, ".stall_on_start"}, {63'd0, ifc.md_stall}, 64'd1);
    e.cyc = cyc; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    ifc.start = 1'b0; ifc.flush_Mem = 1'b0;
    ifc.rs_val = $urandom; ifc.rt_val = $urandom; ifc.md_op = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (ifc.busy && n < 64) begin
      if (n == 0) begin
        chk({name, ".preop_hi"}, {32'd0, ifc.hi}, {32'd0, ph});
        chk({name, ".preop_lo"}, {32'd0, ifc.lo}, {32'd0, pl});
      end
      ifc.flush_Mem = (n == fc);
      ifc.rs_val = $urandom; ifc.rt_val = $urandom;
      n++;
      @(negedge clk);
    end
    ifc.flush_Mem = 1'b0;
    e = sb_q.pop_front();
    chk({name, ".busy_cycles"}, 64'(n), 64'(e.cyc));
    chk({name, ".hi"}, {32'd0, ifc.hi}, {32'd0, e.hi});
    chk({name, ".lo"}, {32'd0, ifc.lo}, {32'd0, e.lo});
    chk({name, ".stall_idle"}, {63'd0, ifc.md_stall}, 64'd0);
    $display("[TB] %s op=%0d rs=%h rt=%h busy=%0d hi=%h lo=%h", name, op, rs, rt, n, ifc.hi, ifc.lo);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;
    tests = 0; fails = 0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    ifc.start = 1'b0; ifc.md_op = 4'd0; ifc.rs_val = 32'd0; ifc.rt_val = 32'd0; ifc.flush_Mem = 1'b0;
    reset_n = 1'b1;

    //          name          op     rs            rt            fs  fc  cyc hi            lo
    add_vec("mult_neg",    4'd0,  32'd5,        32'hFFFFFFFD, 0, -1, 5,  32'hFFFFFFFF, 32'hFFFFFFF1);
    add_vec("divu_7_2",    4'd3,  32'd7,        32'd2,        0, -1, 10, 32'd1,        32'd3);
    add_vec("div_m7_2",    4'd2,  32'hFFFFFFF9, 32'd2,        0, -1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    add_vec("mthi",        4'd4,  32'h1234,     32'd0,        0, -1, 0,  32'h1234,     32'hFFFFFFFD);
    add_vec("div_by_0",    4'd2,  32'd9,        32'd0,        0, -1, 10, 32'h1234,     32'hFFFFFFFD);
    add_vec("multu_flush", 4'd1,  32'd5,        32'd5,        1, -1, 0,  32'h1234,     32'hFFFFFFFD);
    add_vec("mult_flushmid",4'd0, 32'd3,        32'd4,        0, 1,  5,  32'd0,        32'd12);
    add_vec("div_ovf",     4'd2,  32'h80000000, 32'hFFFFFFFF, 0, -1, 10, 32'd0,        32'h80000000);
    add_vec("mtlo",        4'd5,  32'hFFFFFFFF, 32'd0,        0, -1, 0,  32'd0,        32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    add_vec("maddu",       4'd7,  32'd1,        32'd1,        0, -1, 5,  32'd1,        32'd0);
`else
    add_vec("maddu_noop",  4'd7,  32'd1,        32'd1,        0, -1, 0,  32'd0,        32'hFFFFFFFF);
`endif
    add_vec("multu_max",   4'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, 5,  32'hFFFFFFFE, 32'h00000001);
    add_vec("div_7_m2",    4'd2,  32'd7,        32'hFFFFFFFE, 0, -1, 10, 32'd1,        32'hFFFFFFFD);
    add_vec("divu_big",    4'd3,  32'hFFFFFFFF, 32'h10,       0, -1, 10, 32'hF,        32'h0FFFFFFF);
    add_vec("noop_op15",   4'd15, 32'h55,       32'h66,       0, -1, 0,  32'hF,        32'h0FFFFFFF);
    add_vec("mult_m1_m1",  4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, 5,  32'd0,        32'd1);

    #2 reset_n = 1'b0;
    #1;
    chk("reset.busy",  {63'd0, ifc.busy},     64'd0);
    chk("reset.stall", {63'd0, ifc.md_stall}, 64'd0);
    chk("reset.hi",    {32'd0, ifc.hi},       64'd0);
    chk("reset.lo",    {32'd0, ifc.lo},       64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].flush_start,
             vecs[i].flush_cyc, vecs[i].cyc, vecs[i].hi, vecs[i].lo);
    end

    for (int i = 0; i < 8; i++) begin
      rop  = 4'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom);
      rexp = model(rop, ra, rb, {cur_hi, cur_lo});
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0, -1, (rop < 4'd2) ? 5 : 10,
             rexp[63:32], rexp[31:0]);
    end

    // Asynchronous reset in the middle of a divide.
    ifc.start = 1'b1; ifc.md_op = 4'd3; ifc.rs_val = 32'd100; ifc.rt_val = 32'd7;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset.busy_before", {63'd0, ifc.busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset.busy", {63'd0, ifc.busy}, 64'd0);
    chk("midreset.hi",   {32'd0, ifc.hi},   64'd0);
    chk("midreset.lo",   {32'd0, ifc.lo},   64'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midreset.later_busy", {63'd0, ifc.busy}, 64'd0);
    chk("midreset.later_hi",   {32'd0, ifc.hi},   64'd0);
    chk("midreset.later_lo",   {32'd0, ifc.lo},   64'd0);
    $display("[TB] midreset divu 100/7 aborted hi=%h lo=%h", ifc.hi, ifc.lo);
    cur_hi = 32'd0;
    cur_lo = 32'd0;

    run_op("post_reset_mult", 4'd0, 32'd5, 32'hFFFFFFFD, 1'b0, -1, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
